descrambler_block_sequencer: RTL
================================

Name: descrambler_block_sequencer

Overview:
- Clocked controller that sequences the per-lane descrambler LFSR. Per cycle it drives the LFSR advance mask, pattern reset and per-byte descramble enable.
- Gen1/2: decisions are made per byte from K-codes.
- Gen3 (128b/130b): tracks block boundaries and block type across cycles, so decisions for every symbol of an ordered-set block are made from the block's first symbol.
- Sits between the lane's block-alignment/PIPE RX interface and the LFSR/descrambler datapath. Replaces ad-hoc combinational flag holding with explicit state.

Parameters:
- SYMS_PER_BLOCK, 16, symbols per 128b/130b block.
- ERR_CNT_W, 8, width of the optional error counter.

Ports:
- clk  in  1  lane clock.
- reset  in  1  asynchronous, active-high reset.
- gen  in  3  link generation (1, 2, 3).
- pipeWidth  in  6  data width in bits: 8, 16 or 32. Bytes per cycle N = pipeWidth/8.
- rxValid  in  1  rxData holds N valid bytes this cycle.
- blockStart  in  1  Gen3: first symbol of a block is in byte 0 this cycle.
- syncHeader  in  2  Gen3 sync header; sampled only with blockStart.
- rxData  in  32  received bytes; byte k = rxData[8k+7:8k].
- turnOff  in  1  LTSSM bypass: descrambling disabled, LFSR held in reset.
- advance  out  4  per-byte LFSR advance.
- patternReset  out  1  LFSR reseed.
- descramblingEnable  out  4  per-byte descramble enable.
- lfsrSel  out  2  0/1/2 for 8/16/32-bit width.
- blockErr  out  1  one-cycle error pulse.

Behaviour:
- Output timing: all outputs are registered, one cycle after the sampled inputs. Bytes k >= N of every mask are driven 0.
- Reset values: advance=0, descramblingEnable=0, patternReset=1, blockErr=0, lfsrSel=0, FSM=UNALIGNED, symCnt=0.
- lfsrSel: combinational decode of pipeWidth. Any value other than 8/16 gives 2.
- turnOff=1 (highest priority, any gen): patternReset=1, descramblingEnable=0, advance=all N bytes. Gen3 FSM goes to UNALIGNED.
- rxValid=0: advance=0, descramblingEnable=0, patternReset=0. State and counter hold.
- Gen<3, per valid byte:
  - COM (8'hBC) in any byte -> patternReset=1.
  - SKP (8'h1C) byte -> advance bit 0, descramblingEnable bit 0.
  - All other bytes -> advance 1, descramblingEnable 1.
- Gen3 FSM states: UNALIGNED, DATA_BLK, TS_BLK, EIEOS_BLK, SKP_BLK, OS_BLK.
- symCnt counts symbols within a block, 0..15, incremented by N per valid cycle. The block ends when symCnt+N wraps to 0.
- Block start (blockStart=1 with rxValid=1), symCnt reset to 0:
  - syncHeader=01 -> DATA_BLK.
  - syncHeader=10 -> state chosen by byte 0: 8'h1E or 8'h2D -> TS_BLK; 8'h00 -> EIEOS_BLK; 8'hAA -> SKP_BLK; anything else -> OS_BLK.
  - syncHeader=00 or 11 -> blockErr=1, go to UNALIGNED.
- blockStart while symCnt != 0 (mid-block realign): blockErr=1, then the start is processed normally as above.
- Block end without a new blockStart on the following valid cycle: blockErr=1, go to UNALIGNED.
- Per-symbol rules, s = block symbol index:
  - DATA_BLK: advance 1, descramble 1.
  - TS_BLK: advance 1; descramble 0 for s=0, 1 for s>=1.
  - EIEOS_BLK: advance 1, descramble 0. patternReset=1 in the cycle carrying s=15.
  - SKP_BLK: advance 0, descramble 0. The length is still counted as 16 symbols.
  - OS_BLK: advance 1, descramble 0.
  - UNALIGNED: advance 0, descramble 0, patternReset=0.
- Change of gen or pipeWidth while aligned: FSM goes to UNALIGNED, symCnt=0, no blockErr.
- Reset asserted mid-block: immediate return to reset values. The first block after release requires blockStart.

Optional Feature:
- Macro: DESCR_SEQ_ERR_CNT_EN.
- Defined: adds output errCnt[ERR_CNT_W-1:0]. Reset 0; +1 per blockErr pulse; saturates at all-ones; cleared while turnOff=1.
- Undefined: no port, no counter logic.

Test Plan:
- Gen1, width 32, rxData=32'h1C1CBC4A -> next cycle: patternReset=1, advance=4'b0011, descramblingEnable=4'b0011.
- Gen3, width 32, blockStart, header 01, then 4 valid cycles -> descramblingEnable=4'hF and advance=4'hF for all 4 cycles; blockErr=0 when the next blockStart lands on cycle 5.
- Gen3, width 16, header 10, byte 0=8'h1E -> cycle 1: descramblingEnable=4'b0010, advance=4'b0011; cycles 2-8: descramblingEnable=4'b0011.
- Gen3, width 8, EIEOS block (byte 0=8'h00) -> descramblingEnable=0 for 16 cycles; patternReset=1 only on cycle 16.
- Gen3, width 32, SKP block (8'hAA) -> advance=0 for 4 cycles. Then blockStart with header 11 -> blockErr pulse, outputs 0; errCnt=1 when DESCR_SEQ_ERR_CNT_EN is defined.
- Gen3, width 32, blockStart at symCnt=8 -> blockErr=1, new block decoded normally. Reset asserted mid-block -> patternReset=1, masks 0 on the same edge.

Source files
------------

// File: rtl/descrambler_block_sequencer.sv
// Per-lane descrambler LFSR sequencer: Gen1/2 K-code gating, Gen3 block tracking.
// Optional saturating block error counter output with DESCR_SEQ_ERR_CNT_EN.
module descrambler_block_sequencer #(
    parameter int SYMS_PER_BLOCK = 16,
    parameter int ERR_CNT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  gen,
    input  logic [5:0]  pipeWidth,
    input  logic        rxValid,
    input  logic        blockStart,
    input  logic [1:0]  syncHeader,
    input  logic [31:0] rxData,
    input  logic        turnOff,
    output logic [3:0]  advance,
    output logic        patternReset,
    output logic [3:0]  descramblingEnable,
    output logic [1:0]  lfsrSel,
`ifdef DESCR_SEQ_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] errCnt,
`endif
    output logic        blockErr
);

    localparam int CW = $clog2(SYMS_PER_BLOCK);

    typedef enum logic [2:0] {
        UNALIGNED,
        DATA_BLK,
        TS_BLK,
        EIEOS_BLK,
        SKP_BLK,
        OS_BLK
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] symCnt_q, symCnt_d;
    logic [2:0]    gen_q;
    logic [5:0]    width_q;
    logic [3:0]    adv_q, adv_d;
    logic [3:0]    desc_q, desc_d;
    logic          pr_q, pr_d;
    logic          err_q, err_d;
    logic [1:0]    sel_q, sel_d;

    state_e        curState, blkState;
    logic [CW-1:0] curCnt, base;
    logic [CW:0]   sum;
    logic [CW+2:0] s;
    logic [3:0]    nMask;
    logic [2:0]    nBytes;
    logic          isGen3, cfgChg;

    always_comb begin
        sel_d    = 2'd2;
        nMask    = 4'hF;
        nBytes   = 3'd4;
        if (pipeWidth == 6'd8) begin
            sel_d  = 2'd0;
            nMask  = 4'h1;
            nBytes = 3'd1;
        end else if (pipeWidth == 6'd16) begin
            sel_d  = 2'd1;
            nMask  = 4'h3;
            nBytes = 3'd2;
        end

        isGen3   = (gen >= 3'd3);
        cfgChg   = (gen != gen_q) || (pipeWidth != width_q);
        curState = state_q;
        curCnt   = symCnt_q;
        // A config change drops alignment silently; Gen1/2 never holds alignment.
        if (cfgChg || !isGen3) begin
            curState = UNALIGNED;
            curCnt   = '0;
        end

        state_d  = curState;
        symCnt_d = curCnt;
        adv_d    = 4'h0;
        desc_d   = 4'h0;
        pr_d     = 1'b0;
        err_d    = 1'b0;
        blkState = curState;
        base     = curCnt;
        sum      = '0;
        s        = '0;

        if (turnOff) begin
            pr_d     = 1'b1;
            adv_d    = nMask;
            state_d  = UNALIGNED;
            symCnt_d = '0;
        end else if (rxValid) begin
            if (!isGen3) begin
                for (int k = 0; k < 4; k++) begin
                    if (nMask[k]) begin
                        if (rxData[8*k +: 8] == 8'hBC) pr_d = 1'b1;
                        if (rxData[8*k +: 8] != 8'h1C) begin
                            adv_d[k]  = 1'b1;
                            desc_d[k] = 1'b1;
                        end
                    end
                end
            end else begin
                if (blockStart) begin
                    if (curCnt != '0) err_d = 1'b1;
                    base = '0;
                    case (syncHeader)
                        2'b01: blkState = DATA_BLK;
                        2'b10: begin
                            case (rxData[7:0])
                                8'h1E, 8'h2D: blkState = TS_BLK;
                                8'h00:        blkState = EIEOS_BLK;
                                8'hAA:        blkState = SKP_BLK;
                                default:      blkState = OS_BLK;
                            endcase
                        end
                        default: begin
                            err_d    = 1'b1;
                            blkState = UNALIGNED;
                        end
                    endcase
                end else if (curState != UNALIGNED && curCnt == '0) begin
                    // Previous block ended and no new block header arrived.
                    err_d    = 1'b1;
                    blkState = UNALIGNED;
                end

                if (blkState != UNALIGNED) begin
                    for (int k = 0; k < 4; k++) begin
                        s = (CW+3)'(base) + (CW+3)'(k);
                        if (nMask[k]) begin
                            case (blkState)
                                DATA_BLK: begin
                                    adv_d[k]  = 1'b1;
                                    desc_d[k] = 1'b1;
                                end
                                TS_BLK: begin
                                    adv_d[k]  = 1'b1;
                                    desc_d[k] = (s != '0);
                                end
                                EIEOS_BLK: begin
                                    adv_d[k] = 1'b1;
                                    if (s == (CW+3)'(SYMS_PER_BLOCK-1))
                                        pr_d = 1'b1;
                                end
                                OS_BLK:  adv_d[k] = 1'b1;
                                default: adv_d[k] = 1'b0;
                            endcase
                        end
                    end
                    sum = (CW+1)'(base) + (CW+1)'(nBytes);
                    if (sum >= (CW+1)'(SYMS_PER_BLOCK))
                        sum = sum - (CW+1)'(SYMS_PER_BLOCK);
                    symCnt_d = sum[CW-1:0];
                end else begin
                    symCnt_d = '0;
                end
                state_d = blkState;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= UNALIGNED;
            symCnt_q <= '0;
            gen_q    <= '0;
            width_q  <= '0;
            adv_q    <= '0;
            desc_q   <= '0;
            pr_q     <= 1'b1;
            err_q    <= 1'b0;
            sel_q    <= '0;
        end else begin
            state_q  <= state_d;
            symCnt_q <= symCnt_d;
            gen_q    <= gen;
            width_q  <= pipeWidth;
            adv_q    <= adv_d;
            desc_q   <= desc_d;
            pr_q     <= pr_d;
            err_q    <= err_d;
            sel_q    <= sel_d;
        end
    end

`ifdef DESCR_SEQ_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] errCnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            errCnt_q <= '0;
        end else if (turnOff) begin
            errCnt_q <= '0;
        end else if (err_d && errCnt_q != '1) begin
            errCnt_q <= errCnt_q + 1'b1;
        end
    end

    assign errCnt = errCnt_q;
`endif

    assign advance            = adv_q;
    assign descramblingEnable = desc_q;
    assign patternReset       = pr_q;
    assign blockErr           = err_q;
    assign lfsrSel            = sel_q;

endmodule
